radix8_digit_mul: RTL and testbench

RADIX8_DIGIT_MUL -- requirements
Module: radix8_digit_mul

---
 rtl/radix8_digit_mul.sv | 108 ++++++++++
 tb/tb_radix8_digit_mul.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/radix8_digit_mul.sv
// Radix-8 digit-serial multiplier: 32x32 -> 64 over eleven 3-bit digits.
// Optional SIGNED_CORR_EN adds a CORR cycle that treats D as signed.
module radix8_digit_mul (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] A,
  input  logic        d_sign,
  input  logic [2:0]  digit,
  output logic [3:0]  i,
  output logic        busy,
  output logic        done,
  output logic [63:0] product
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    CORR
  } state_t;

  state_t      state, state_n;
  logic [3:0]  i_n;
  logic [63:0] acc, acc_n;
  logic [63:0] prod_n;
  logic [31:0] a_q, a_n;
  logic        sgn_q, sgn_n;
  logic        done_n;

  logic signed [34:0] a35, d35, term;
  logic [63:0]        step;
  logic [63:0]        corr;

  // digit is zero-extended so the partial product stays a 35-bit signed value
  assign a35  = {{3{a_q[31]}}, a_q};
  assign d35  = {32'd0, digit};
  assign term = a35 * d35;
  assign step = (acc << 3) + {{29{term[34]}}, term};
  assign corr = acc - (sgn_q ? {a_q, 32'd0} : 64'd0);

  assign busy = (state != IDLE);

  always_comb begin
    state_n = state;
    i_n     = i;
    acc_n   = acc;
    a_n     = a_q;
    sgn_n   = sgn_q;
    prod_n  = product;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !done) begin
          a_n     = A;
          sgn_n   = d_sign;
          acc_n   = 64'd0;
          i_n     = 4'd0;
          state_n = RUN;
        end
      end
      RUN: begin
        acc_n = step;
        if (i == 4'd10) begin
          i_n = 4'd0;
`ifdef SIGNED_CORR_EN
          state_n = CORR;
`else
          state_n = IDLE;
          prod_n  = step;
          done_n  = 1'b1;
`endif
        end else begin
          i_n = i + 4'd1;
        end
      end
      CORR: begin
        prod_n  = corr;
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        i_n     = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      i       <= 4'd0;
      acc     <= 64'd0;
      a_q     <= 32'd0;
      sgn_q   <= 1'b0;
      product <= 64'd0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      i       <= i_n;
      acc     <= acc_n;
      a_q     <= a_n;
      sgn_q   <= sgn_n;
      product <= prod_n;
      done    <= done_n;
    end
  end

endmodule

// File: tb/tb_radix8_digit_mul.sv
// Directed bench for radix8_digit_mul; models the digit-select stage.
// Expectations follow SIGNED_CORR_EN when it is defined.
module tb_radix8_digit_mul;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic        d_sign;
  logic [2:0]  digit;
  logic [3:0]  i;
  logic        busy;
  logic        done;
  logic [63:0] product;
  logic [31:0] dval;

  int n_run;
  int n_fail;

`ifdef SIGNED_CORR_EN
  localparam int LAT = 12;
`else
  localparam int LAT = 11;
`endif

  radix8_digit_mul dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .A      (a),
    .d_sign (d_sign),
    .digit  (digit),
    .i      (i),
    .busy   (busy),
    .done   (done),
    .product(product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign d_sign = dval[31];

  // digit k covers D bits [32-3k : 30-3k] with bit 32 = 0
  always_comb begin
    logic [32:0] dz;
    logic [32:0] sh;
    int          amt;
    digit = 3'd0;
    dz    = {1'b0, dval};
    sh    = '0;
    amt   = 0;
    if (i <= 4'd10) begin
      amt   = 30 - 3 * int'(i);
      sh    = dz >> amt;
      digit = sh[2:0];
    end
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_mul(input string tag, input logic [31:0] av,
                         input logic [31:0] dv, input logic [63:0] exp,
                         input int re_at, input logic [31:0] re_a,
                         input bit start_on_done);
    int   c;
    int   bc;
    logic iok;
    int   ei;
    @(negedge clk);
    a     = av;
    dval  = dv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c     = 0;
    bc    = 0;
    iok   = 1'b1;
    while (!done && c < 30) begin
      if (busy) bc++;
      ei = (c <= 10) ? c : 0;
      if (int'(i) != ei) iok = 1'b0;
      if (c == re_at) begin
        start = 1'b1;
        a     = re_a;
      end
      @(negedge clk);
      c++;
      start = 1'b0;
    end
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_lat"}, 64'(c), 64'(LAT));
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    check({tag, "_busy_cnt"}, 64'(bc), 64'(LAT));
    check({tag, "_iseq"}, 64'(iok), 64'd1);
    check({tag, "_i_end"}, 64'(i), 64'd0);
    check({tag, "_prod"}, product, exp);
    if (start_on_done) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_idle_after"}, 64'(busy), 64'd0);
    check({tag, "_prod_held"}, product, exp);
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    a      = '0;
    dval   = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_i", 64'(i), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_prod", product, 64'd0);
    rst_n = 1'b1;

    run_mul("a3d5", 32'd3, 32'd5, 64'd15, -1, 32'd0, 1'b0);
`ifdef SIGNED_CORR_EN
    run_mul("m1ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF,
            64'h0000_0000_0000_0001, -1, 32'd0, 1'b0);
    run_mul("max_min", 32'h7FFF_FFFF, 32'h8000_0000,
            64'hC000_0000_8000_0000, -1, 32'd0, 1'b0);
    run_mul("m1_min", 32'hFFFF_FFFF, 32'h8000_0000,
            64'h0000_0000_8000_0000, -1, 32'd0, 1'b0);
`else
    run_mul("m1ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF,
            64'hFFFF_FFFF_0000_0001, -1, 32'd0, 1'b0);
    run_mul("max_min", 32'h7FFF_FFFF, 32'h8000_0000,
            64'h3FFF_FFFF_8000_0000, -1, 32'd0, 1'b0);
    run_mul("m1_min", 32'hFFFF_FFFF, 32'h8000_0000,
            64'hFFFF_FFFF_8000_0000, -1, 32'd0, 1'b0);
`endif
    run_mul("neg7", 32'hFFFF_FFF9, 32'h1234_5678,
            64'hFFFF_FFFF_8091_A2B8, -1, 32'd0, 1'b0);
    run_mul("shift8", 32'h1234_5678, 32'h0000_0100,
            64'h0000_0012_3456_7800, -1, 32'd0, 1'b1);
    run_mul("restart", 32'd1000, 32'd123, 64'd123000, 4, 32'd77, 1'b0);

    @(negedge clk);
    a     = 32'd5;
    dval  = 32'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_busy", 64'(busy), 64'd0);
    check("async_i", 64'(i), 64'd0);
    check("async_prod", product, 64'd0);
    check("async_done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_mul("a2d7", 32'd2, 32'd7, 64'd14, -1, 32'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
